matrix_result_streamer: RTL and testbench

//  Read-side companion to the matrix multiplier. After the multiplier pulses

---
 rtl/matrix_result_streamer.sv | 123 ++++++++++++
 tb/tb_matrix_result_streamer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_streamer.sv
// Walks the result matrix in row-major order after the multiplier finishes and
// streams each element with its row/col tag over a valid/ready handshake.
module matrix_result_streamer #(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_CAPT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
    localparam logic [7:0] LAST_COL = 8'(COLS - 1);

    logic [2:0]        r_state;
    logic [7:0]        r_row;
    logic [7:0]        r_col;
    logic [ADDR_W-1:0] r_addr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [7:0]        r_out_row;
    logic [7:0]        r_out_col;
    logic              r_out_last;

    logic w_is_last;
    logic w_handshake;

    assign w_is_last   = (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_handshake = r_out_valid && out_ready;

    // Strobes are decoded from the registered state, so they are glitch-free
    // and mem_read can only ever be high while in REQ.
    assign mem_read         = (r_state == S_REQ);
    assign done             = (r_state == S_DONE);
    assign busy             = (r_state == S_REQ) || (r_state == S_CAPT) || (r_state == S_HOLD);
    assign mem_read_address = r_addr;
    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;
    assign out_row          = r_out_row;
    assign out_col          = r_out_col;
    assign out_last         = r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= 8'd0;
            r_col       <= 8'd0;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= 8'd0;
            r_out_col   <= 8'd0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row   <= 8'd0;
                        r_col   <= 8'd0;
                        r_addr  <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    // Read data is valid exactly one cycle after the strobe.
                    r_out_data  <= mem_data;
                    r_out_row   <= r_row;
                    r_out_col   <= r_col;
                    r_out_last  <= w_is_last;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                            if (r_col == LAST_COL) begin
                                r_col <= 8'd0;
                                r_row <= r_row + 8'd1;
                            end else begin
                                r_col <= r_col + 8'd1;
                            end
                            r_state <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Scoreboard bench: a 2x2 and a 3x2 streamer, each fed by a registered-read memory model.
module tb_matrix_result_streamer;
    localparam int DW = 16;
    localparam int AW = 6;

    typedef struct {
        logic [7:0]    row;
        logic [7:0]    col;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b0;
    logic a_start = 1'b0;
    logic b_start = 1'b0;
    logic sel_b = 1'b0;

    logic          a_mem_read, b_mem_read;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_mem_data, b_mem_data;
    logic          a_out_valid, b_out_valid;
    logic [DW-1:0] a_out_data, b_out_data;
    logic [7:0]    a_out_row, b_out_row, a_out_col, b_out_col;
    logic          a_out_last, b_out_last, a_busy, b_busy, a_done, b_done;

    logic          m_valid, m_last, m_busy, m_done;
    logic [DW-1:0] m_data;
    logic [7:0]    m_row, m_col;

    logic [DW-1:0] mem_a [4];
    logic [DW-1:0] mem_b [6];

    beat_t exp_q[$];
    int    a_rd_log[$];
    int    b_rd_log[$];
    int    a_done_cnt = 0, b_done_cnt = 0, a_rd_double = 0, b_rd_double = 0;
    logic  a_rd_prev = 1'b0, b_rd_prev = 1'b0;
    int    total = 0, passed = 0, failed = 0;
    int    d0;

    always #5 clk = ~clk;

    matrix_result_streamer #(.ROWS(2), .COLS(2), .DATA_W(DW), .ADDR_W(AW)) dut_a (
        .clk(clk), .rst(rst), .start(a_start),
        .mem_read(a_mem_read), .mem_read_address(a_addr), .mem_data(a_mem_data),
        .out_valid(a_out_valid), .out_ready(ready), .out_data(a_out_data),
        .out_row(a_out_row), .out_col(a_out_col), .out_last(a_out_last),
        .busy(a_busy), .done(a_done)
    );

    matrix_result_streamer #(.ROWS(3), .COLS(2), .DATA_W(DW), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst(rst), .start(b_start),
        .mem_read(b_mem_read), .mem_read_address(b_addr), .mem_data(b_mem_data),
        .out_valid(b_out_valid), .out_ready(ready), .out_data(b_out_data),
        .out_row(b_out_row), .out_col(b_out_col), .out_last(b_out_last),
        .busy(b_busy), .done(b_done)
    );

    // Memory models return X except in the cycle right after a strobe.
    always @(posedge clk) begin
        a_mem_data <= (a_mem_read && int'(a_addr) < 4) ? mem_a[int'(a_addr)] : 'x;
        b_mem_data <= (b_mem_read && int'(b_addr) < 6) ? mem_b[int'(b_addr)] : 'x;
    end

    always @(posedge clk) begin
        a_rd_prev <= a_mem_read;
        b_rd_prev <= b_mem_read;
        if (a_mem_read) a_rd_log.push_back(int'(a_addr));
        if (b_mem_read) b_rd_log.push_back(int'(b_addr));
        if (a_mem_read && a_rd_prev) a_rd_double <= a_rd_double + 1;
        if (b_mem_read && b_rd_prev) b_rd_double <= b_rd_double + 1;
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
    end

    always_comb begin
        if (sel_b) begin
            m_valid = b_out_valid; m_data = b_out_data; m_row = b_out_row;
            m_col = b_out_col; m_last = b_out_last; m_busy = b_busy; m_done = b_done;
        end else begin
            m_valid = a_out_valid; m_data = a_out_data; m_row = a_out_row;
            m_col = a_out_col; m_last = a_out_last; m_busy = a_busy; m_done = a_done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int rows, input int cols);
        beat_t e;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                e.row = 8'(r);
                e.col = 8'(c);
                if (sel_b) e.data = mem_b[r * cols + c];
                else       e.data = mem_a[r * cols + c];
                e.last = (r == rows - 1) && (c == cols - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Waits (bounded) for out_valid, optionally stalls, then compares and pops.
    task automatic get_beat(input int stall, input bit poke, input int lat, input bit abort);
        int    n;
        beat_t e;
        n = 0;
        do begin
            @(negedge clk);
            a_start = 1'b0;
            b_start = 1'b0;
            ready = (stall == 0);
            n++;
        end while (!m_valid && n < 20);
        if (!m_valid) begin
            check("beat_timeout", 64'(m_valid), 64'(1));
            return;
        end
        if (lat != 0) check("latency", 64'(n), 64'(lat));
        check("q_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() == 0) return;
        e = exp_q[0];
        if (abort) return;
        for (int k = 0; k < stall; k++) begin
            check("stall_hold", 64'({m_valid, m_row, m_col, m_data, m_last}),
                  64'({1'b1, e.row, e.col, e.data, e.last}));
            a_start = (poke && k == 1);
            @(negedge clk);
        end
        a_start = 1'b0;
        $display("beat row=%0d col=%0d data=%h last=%0b", m_row, m_col, m_data, m_last);
        check("beat", 64'({m_valid, m_row, m_col, m_data, m_last}),
              64'({1'b1, e.row, e.col, e.data, e.last}));
        void'(exp_q.pop_front());
        ready = 1'b1;
    endtask

    task automatic finish_dump();
        @(negedge clk);
        check("done_pulse", 64'({m_done, m_busy, m_valid}), 64'(3'b100));
        @(negedge clk);
        check("done_clear", 64'({m_done, m_busy}), 64'(0));
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        ready = 1'b0;
    endtask

    initial begin
        mem_a = '{16'h0010, 16'h0022, 16'h0033, 16'h0044};
        mem_b = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};

        repeat (3) @(negedge clk);
        check("reset_a", 64'({a_mem_read, a_addr, a_out_valid, a_out_data, a_out_row,
                              a_out_col, a_out_last, a_busy, a_done}), 64'(0));
        check("reset_b", 64'({b_mem_read, b_addr, b_out_valid, b_out_data, b_out_row,
                              b_out_col, b_out_last, b_busy, b_done}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Full-rate dump with read-strobe logging
        a_rd_log.delete();
        d0 = a_done_cnt;
        push_exp(2, 2);
        ready = 1'b1;
        a_start = 1'b1;
        for (int i = 0; i < 4; i++) get_beat(0, 1'b0, 3, 1'b0);
        finish_dump();
        check("done_count_full", 64'(a_done_cnt - d0), 64'(1));
        check("rd_count", 64'(a_rd_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < a_rd_log.size()) check("rd_addr", 64'(a_rd_log[i]), 64'(i));
        end
        check("rd_single_cycle", 64'(a_rd_double), 64'(0));

        // Stalled dump
        d0 = a_done_cnt;
        push_exp(2, 2);
        a_start = 1'b1;
        for (int i = 0; i < 4; i++) get_beat(5, 1'b0, 0, 1'b0);
        finish_dump();
        check("done_count_stall", 64'(a_done_cnt - d0), 64'(1));

        // Start pulse while busy must be ignored
        d0 = a_done_cnt;
        push_exp(2, 2);
        ready = 1'b1;
        a_start = 1'b1;
        get_beat(0, 1'b0, 3, 1'b0);
        get_beat(3, 1'b1, 0, 1'b0);
        get_beat(0, 1'b0, 0, 1'b0);
        get_beat(0, 1'b0, 0, 1'b0);
        finish_dump();
        repeat (4) @(negedge clk);
        check("no_requeue", 64'({m_busy, m_valid}), 64'(0));
        check("done_count_poke", 64'(a_done_cnt - d0), 64'(1));

        // Reset while holding beat 3, then replay
        d0 = a_done_cnt;
        push_exp(2, 2);
        ready = 1'b1;
        a_start = 1'b1;
        get_beat(0, 1'b0, 3, 1'b0);
        get_beat(0, 1'b0, 3, 1'b0);
        get_beat(2, 1'b0, 0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid", 64'({m_valid, m_busy, m_done}), 64'(0));
        repeat (3) @(negedge clk);
        check("rst_no_done", 64'(a_done_cnt - d0), 64'(0));
        exp_q.delete();
        d0 = a_done_cnt;
        push_exp(2, 2);
        ready = 1'b1;
        a_start = 1'b1;
        for (int i = 0; i < 4; i++) get_beat(0, 1'b0, 3, 1'b0);
        finish_dump();
        check("done_count_replay", 64'(a_done_cnt - d0), 64'(1));

        // 3x2 instance
        sel_b = 1'b1;
        b_rd_log.delete();
        d0 = b_done_cnt;
        push_exp(3, 2);
        ready = 1'b1;
        b_start = 1'b1;
        for (int i = 0; i < 6; i++) get_beat(0, 1'b0, 3, 1'b0);
        finish_dump();
        check("b_done_count", 64'(b_done_cnt - d0), 64'(1));
        check("b_rd_count", 64'(b_rd_log.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < b_rd_log.size()) check("b_rd_addr", 64'(b_rd_log[i]), 64'(i));
        end
        check("b_rd_single_cycle", 64'(b_rd_double), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
